// File: rtl/compare_guesser.sv
// Binary-search guesser driving comparator A and narrowing [lo,hi] from GT/EQ/LT feedback.
// Optional feedback timeout is enabled with COMPARE_GUESSER_TIMEOUT_EN.
module compare_guesser #(
   parameter int WIDTH   = 4,
   parameter int TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             fb_valid,
   input  logic             fb_gt,
   input  logic             fb_eq,
   input  logic             fb_lt,
   output logic [WIDTH-1:0] guess,
   output logic             guess_valid,
   output logic             busy,
   output logic             done,
   output logic             found,
   output logic             err,
   output logic [3:0]       tries
);

   typedef enum logic [1:0] {S_IDLE, S_PROPOSE, S_WAIT, S_DONE} state_t;

   localparam logic [WIDTH:0] HI_MAX = (WIDTH+1)'((1 << WIDTH) - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] guess_q, guess_d;
   logic [WIDTH:0]   lo_q, lo_d, hi_q, hi_d;
   logic [3:0]       tries_q, tries_d;
   logic             found_q, found_d, err_q, err_d;
   logic [WIDTH+1:0] sum;
   logic [WIDTH:0]   guess_x;
   logic             legal;
   logic             timeout;

   assign sum     = {1'b0, lo_q} + {1'b0, hi_q};
   assign guess_x = {1'b0, guess_q};
   assign legal   = $onehot({fb_gt, fb_eq, fb_lt});

`ifdef COMPARE_GUESSER_TIMEOUT_EN
   logic [3:0] wcnt_q, wcnt_d;

   // Counter sits at zero outside WAIT, so it is fresh on every WAIT entry.
   always_comb begin
      wcnt_d = '0;
      if (state_q == S_WAIT && wcnt_q != 4'hF) wcnt_d = wcnt_q + 4'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) wcnt_q <= '0;
      else        wcnt_q <= wcnt_d;
   end

   assign timeout = (state_q == S_WAIT) && (wcnt_q == 4'(TIMEOUT - 1));
`else
   assign timeout = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      guess_d = guess_q;
      lo_d    = lo_q;
      hi_d    = hi_q;
      tries_d = tries_q;
      found_d = found_q;
      err_d   = err_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d = S_PROPOSE;
               lo_d    = '0;
               hi_d    = HI_MAX;
               tries_d = '0;
               found_d = 1'b0;
               err_d   = 1'b0;
            end
         end
         S_PROPOSE: begin
            guess_d = sum[WIDTH:1];
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (fb_valid) begin
               if (tries_q != 4'hF) tries_d = tries_q + 4'd1;
               state_d = S_DONE;
               if (!legal) begin
                  err_d = 1'b1;
               end else if (fb_eq) begin
                  found_d = 1'b1;
               end else if (fb_gt) begin
                  // GT at the bottom of the range means the feedback contradicts itself.
                  if (guess_x == lo_q) err_d = 1'b1;
                  else begin
                     hi_d    = guess_x - 1'b1;
                     state_d = S_PROPOSE;
                  end
               end else begin
                  if (guess_x == hi_q) err_d = 1'b1;
                  else begin
                     lo_d    = guess_x + 1'b1;
                     state_d = S_PROPOSE;
                  end
               end
            end else if (timeout) begin
               err_d   = 1'b1;
               state_d = S_DONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         guess_q <= '0;
         lo_q    <= '0;
         hi_q    <= HI_MAX;
         tries_q <= '0;
         found_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         guess_q <= guess_d;
         lo_q    <= lo_d;
         hi_q    <= hi_d;
         tries_q <= tries_d;
         found_q <= found_d;
         err_q   <= err_d;
      end
   end

   assign guess       = guess_q;
   assign guess_valid = (state_q == S_WAIT);
   assign busy        = (state_q == S_PROPOSE) || (state_q == S_WAIT);
   assign done        = (state_q == S_DONE);
   assign found       = found_q;
   assign err         = err_q;
   assign tries       = tries_q;

endmodule

// File: tb/tb_compare_guesser.sv
// Directed bench for compare_guesser (WIDTH=4): acts as the comparator and checks guesses/results.
module tb_compare_guesser;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic       fb_valid = 1'b0;
   logic       fb_gt = 1'b0;
   logic       fb_eq = 1'b0;
   logic       fb_lt = 1'b0;
   logic [3:0] guess;
   logic       guess_valid, busy, done, found, err;
   logic [3:0] tries;

   int checks = 0;
   int errors = 0;

   compare_guesser #(.WIDTH(4), .TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .fb_valid(fb_valid), .fb_gt(fb_gt), .fb_eq(fb_eq), .fb_lt(fb_lt),
      .guess(guess), .guess_valid(guess_valid), .busy(busy), .done(done),
      .found(found), .err(err), .tries(tries)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_result(input string tag, input logic f, input logic e, input logic [3:0] t);
      chk({tag, " done"}, 32'(done), 32'd1);
      chk({tag, " busy"}, 32'(busy), 32'd0);
      chk({tag, " found"}, 32'(found), 32'(f));
      chk({tag, " err"}, 32'(err), 32'(e));
      chk({tag, " tries"}, 32'(tries), 32'(t));
   endtask

   // mode 0: ideal comparator, 1: always GT, 2: GT+LT together, 3: no flags
   task automatic search(input string tag, input logic [3:0] secret, input int mode,
                         input logic [23:0] eg, input int ng);
      int k;
      int cyc;
      k = 0;
      cyc = 0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, " busy after start"}, 32'(busy), 32'd1);
      chk({tag, " no guess_valid in PROPOSE"}, 32'(guess_valid), 32'd0);
      while (!done && cyc < 200) begin
         if (guess_valid) begin
            if (k < ng) chk({tag, " guess"}, 32'(guess), 32'(eg[4*k +: 4]));
            k++;
            case (mode)
               0: begin
                  fb_gt = (guess > secret);
                  fb_eq = (guess == secret);
                  fb_lt = (guess < secret);
               end
               1: fb_gt = 1'b1;
               2: begin fb_gt = 1'b1; fb_lt = 1'b1; end
               default: ;
            endcase
            fb_valid = 1'b1;
            @(negedge clk);
            fb_valid = 1'b0;
            fb_gt = 1'b0;
            fb_eq = 1'b0;
            fb_lt = 1'b0;
         end else begin
            @(negedge clk);
         end
         cyc++;
      end
      chk({tag, " search finished in budget"}, 32'(cyc < 200), 32'd1);
      chk({tag, " guess count"}, 32'(k), 32'(ng));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #12;
      rst_n = 1'b1;
   endtask

   initial begin
      // reset state
      #3;
      chk("rst guess", 32'(guess), 32'd0);
      chk("rst guess_valid", 32'(guess_valid), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst done", 32'(done), 32'd0);
      chk("rst found", 32'(found), 32'd0);
      chk("rst err", 32'(err), 32'd0);
      chk("rst tries", 32'(tries), 32'd0);
      #9;
      rst_n = 1'b1;

      // 1: secret 11 -> 7, 11
      search("s11", 4'd11, 0, {16'h0, 4'd11, 4'd7}, 2);
      chk_result("s11", 1'b1, 1'b0, 4'd2);
      chk("s11 guess held", 32'(guess), 32'd11);
      // feedback in DONE must be ignored
      @(negedge clk);
      fb_valid = 1'b1; fb_eq = 1'b1;
      @(negedge clk);
      fb_valid = 1'b0; fb_eq = 1'b0;
      chk("fb in DONE tries", 32'(tries), 32'd2);
      chk("fb in DONE done", 32'(done), 32'd1);

      // 2: boundaries
      search("s0", 4'd0, 0, {8'h0, 4'd0, 4'd1, 4'd3, 4'd7}, 4);
      chk_result("s0", 1'b1, 1'b0, 4'd4);
      search("s15", 4'd15, 0, {4'h0, 4'd15, 4'd14, 4'd13, 4'd11, 4'd7}, 5);
      chk_result("s15", 1'b1, 1'b0, 4'd5);

      // 3: always GT -> contradiction at 0
      search("allgt", 4'd0, 1, {8'h0, 4'd0, 4'd1, 4'd3, 4'd7}, 4);
      chk_result("allgt", 1'b0, 1'b1, 4'd4);

      // 4: illegal flag combinations
      search("gtlt", 4'd0, 2, {20'h0, 4'd7}, 1);
      chk_result("gtlt", 1'b0, 1'b1, 4'd1);
      search("noflag", 4'd0, 3, {20'h0, 4'd7}, 1);
      chk_result("noflag", 1'b0, 1'b1, 4'd1);

      // 5: async reset in WAIT, then restart with secret 5
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("pre-reset guess_valid", 32'(guess_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async rst guess", 32'(guess), 32'd0);
      chk("async rst guess_valid", 32'(guess_valid), 32'd0);
      chk("async rst busy", 32'(busy), 32'd0);
      chk("async rst done", 32'(done), 32'd0);
      chk("async rst tries", 32'(tries), 32'd0);
      #8;
      rst_n = 1'b1;
      search("s5", 4'd5, 0, {12'h0, 4'd5, 4'd3, 4'd7}, 3);
      chk_result("s5", 1'b1, 1'b0, 4'd3);

      // 6: withheld feedback
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
`ifdef COMPARE_GUESSER_TIMEOUT_EN
      begin
         int n;
         n = 0;
         while (!done && n < 40) begin
            @(negedge clk);
            n++;
         end
         // 1 cycle PROPOSE->WAIT, then 15 WAIT cycles
         chk("timeout cycles", 32'(n), 32'd16);
         chk_result("timeout", 1'b0, 1'b1, 4'd0);
      end
`else
      begin
         int low;
         low = 0;
         for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) low++;
         end
         chk("no-timeout busy held", 32'(low), 32'd0);
         chk("no-timeout done", 32'(done), 32'd0);
      end
`endif
      do_reset();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
